uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
- UART transmitter with parameterised baud divider, optional parity and 1 or 2 stop bits.
- Byte accepted through a valid/ready handshake, then serialised LSB-first as 8N1 / 8E1 / 8O1 / 8x2.
- Pairs with the uart_rx receiver on the same clock domain.
- Sits between the command/response logic and the board TX pin.

Parameters:
- CLKS_PER_BIT, 135: clocks per bit = f(i_Clock)/baud. Range 2..2047 (11-bit counter).
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2 stop bits.

Ports:
- i_Clock  in  1  system clock; all state on rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Tx_DV  in  1  byte valid; sampled only while o_Tx_Ready=1.
- i_Tx_Byte  in  8  byte to send; captured on the accept edge.
- o_Tx_Ready  out  1  high only in IDLE; accept = i_Tx_DV & o_Tx_Ready.
- o_Tx_Active  out  1  high from start bit through last stop bit.
- o_Tx_Serial  out  1  serial line, registered, idle high.
- o_Tx_Done  out  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset (async assert, sync release), takes effect immediately, including mid-frame:
  - state=IDLE; o_Tx_Serial=1; o_Tx_Active=0; o_Tx_Done=0; o_Tx_Ready=1.
  - Counters cleared; shift register cleared.
  - A frame cut off by reset is abandoned, never resumed.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> CLEANUP -> IDLE.
- IDLE, on the accept edge:
  - latch i_Tx_Byte; compute parity bit (odd: ~^byte; even: ^byte);
  - set o_Tx_Serial=0 and o_Tx_Active=1 on that same edge;
  - enter START.
- Bit timing: each bit (start, data, parity, stop) is held exactly CLKS_PER_BIT cycles.
  - Counter runs 0..CLKS_PER_BIT-1; the next bit is driven on the edge where the counter equals CLKS_PER_BIT-1.
- DATA: bit index 0..7, LSB first. After index 7, go to PARITY if PARITY!=0, else STOP.
- STOP: line=1 for STOP_BITS*CLKS_PER_BIT cycles.
- On the final STOP edge: o_Tx_Active=0, o_Tx_Done=1, enter CLEANUP.
- CLEANUP lasts 1 cycle: o_Tx_Done=1, o_Tx_Ready=0, line=1. Next edge: o_Tx_Done=0, IDLE.
- Latency: accept edge to o_Tx_Done rising = (9 + (PARITY!=0) + STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back: i_Tx_DV held high yields frames separated by exactly 1 idle-high cycle (CLEANUP) plus the accept cycle. No byte is dropped or duplicated.
- i_Tx_DV while busy: ignored, no queuing. i_Tx_Byte changes after accept do not affect the frame in flight.
- Unused/illegal state encoding: return to IDLE with line=1.
- o_Tx_Serial is driven only from a flop; no combinational glitch path to the pin.

Decomposition:
- Shared package uart_pkg:
  - state encodings (3-bit: IDLE, START, DATA, PARITY, STOP, CLEANUP);
  - parity codes PAR_NONE/PAR_ODD/PAR_EVEN;
  - counter width constant (11).
- One sub-module, uart_baud_cnt:
  - inputs: clear, enable;
  - output: bit_end pulse at count CLKS_PER_BIT-1.
  - Also reusable by uart_rx.

Test Plan:
- Reset, no DV, 1000 cycles -> o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, no o_Tx_Done.
- CLKS_PER_BIT=4, PARITY=0, byte 0xA5 -> line samples 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. o_Tx_Done high 40 cycles after accept, width 1.
- CLKS_PER_BIT=4, byte 0xA5 (4 ones):
  - PARITY=2 -> parity bit 0;
  - PARITY=1 -> parity bit 1;
  - both give an 11-bit frame, Done at 44 cycles.
  - Byte 0x01 with PARITY=2 -> parity bit 1.
- STOP_BITS=2, byte 0xFF -> stop high for 8 cycles; i_Tx_DV pulsed mid-frame with 0x00 -> ignored, only one frame sent.
- i_Tx_DV held high, bytes 0x00, 0xFF, 0x55 -> three frames, exactly 1 CLEANUP cycle + 1 accept cycle between a stop end and the next start.
- i_Rst_n low at data bit 3 -> o_Tx_Serial=1 asynchronously, Active=0, no Done. After release, byte 0x3C sent cleanly.
- Loopback o_Tx_Serial into uart_rx, CLKS_PER_BIT=135, PARITY=0, bytes 0x00..0xFF -> every byte received with o_Rx_DV, values match.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity mode codes,
// baud counter width and the parity helper used when a byte is latched.
package uart_pkg;

    localparam int CNT_W    = 11;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } tx_state_e;

    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic xor_s;
        xor_s = ^data;
        case (mode)
            PAR_ODD:  parity_bit = ~xor_s;
            PAR_EVEN: parity_bit = xor_s;
            default:  parity_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled and flags the
// last count of each bit period; shared by the UART transmitter and receiver.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 135
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic bit_end_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the end of each bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = enable_i && !clear_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: valid/ready byte intake, LSB-first serialisation with
// optional parity and one or two stop bits; every output driven from a flop.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 135,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    tx_state_e  state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       par_q, par_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       serial_q, serial_d;
    logic       active_q, active_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;
    logic       cnt_clear_s;
    logic       bit_end_s;

    // The counter is parked at zero outside a frame so START always gets a full period.
    assign cnt_clear_s = (state_q == S_IDLE) || (state_q == S_CLEANUP);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk_i    (i_Clock),
        .rst_ni   (i_Rst_n),
        .clear_i  (cnt_clear_s),
        .enable_i (!cnt_clear_s),
        .bit_end_o(bit_end_s)
    );

    // Next-state and next-output logic; the next line level is decided one edge ahead.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_d      = par_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        serial_d   = serial_q;
        active_d   = active_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                if (i_Tx_DV && ready_q) begin
                    data_d     = i_Tx_Byte;
                    par_d      = parity_bit(i_Tx_Byte, PARITY);
                    bit_idx_d  = 3'd0;
                    stop_idx_d = 1'b0;
                    serial_d   = 1'b0;
                    active_d   = 1'b1;
                    state_d    = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    serial_d = data_q[0];
                    data_d   = {1'b0, data_q[7:1]};
                    state_d  = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY != PAR_NONE) begin
                            serial_d = par_q;
                            state_d  = S_PARITY;
                        end else begin
                            serial_d = 1'b1;
                            state_d  = S_STOP;
                        end
                    end else begin
                        serial_d  = data_q[0];
                        data_d    = {1'b0, data_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    serial_d = 1'b1;
                    state_d  = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                serial_d = 1'b1;
                if (bit_end_s) begin
                    if ((STOP_BITS == 2) && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_CLEANUP;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_CLEANUP: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= S_IDLE;
            data_q     <= 8'h00;
            par_q      <= 1'b0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
    assign o_Tx_Ready  = ready_q;

endmodule
